lsu_mem_ctrl: RTL

- Load/store controller between the CPU MEM stage and the byte-banked 32-bit data memory (Memoria32Data).
- Accepts one load or store request at a time and drives memory address, byte-write enables and store data.
- Waits out the synchronous read latency, then sign- or zero-extends load data.
- Returns a response over a valid/ready handshake.

---
 rtl/lsu_pkg.sv | 42 ++++
 rtl/lsu_mem_ctrl_if.sv | 40 ++++
 rtl/lsu_load_extend.sv | 21 ++
 rtl/lsu_mem_ctrl.sv | 127 ++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store controller: access sizes,
// controller states and the per-size byte write enables.
package lsu_pkg;

    typedef enum logic [2:0] {
        SIZE_B  = 3'b000,
        SIZE_H  = 3'b001,
        SIZE_W  = 3'b010,
        SIZE_BU = 3'b100,
        SIZE_HU = 3'b101
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RESP
    } lsu_state_e;

    localparam logic [3:0] WR_B = 4'b0001;
    localparam logic [3:0] WR_H = 4'b0011;
    localparam logic [3:0] WR_W = 4'b1111;

    // Unused funct3 codes (011, 110, 111) fall back to a full word access.
    function automatic lsu_size_e decode_size(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return SIZE_B;
            3'b001:  return SIZE_H;
            3'b100:  return SIZE_BU;
            3'b101:  return SIZE_HU;
            default: return SIZE_W;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input lsu_size_e size);
        case (size)
            SIZE_B, SIZE_BU: return WR_B;
            SIZE_H, SIZE_HU: return WR_H;
            default:         return WR_W;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Request, response and data-memory signals of the load/store controller.
// The slave modport is the controller; master is the CPU/memory side.
interface lsu_mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [4:0]        req_tag;

    logic [ADDR_W-1:0] mem_raddress;
    logic [ADDR_W-1:0] mem_waddress;
    logic [31:0]       mem_datain;
    logic [3:0]        mem_wr;
    logic [31:0]       mem_dataout;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_data;
    logic [4:0]        rsp_tag;
    logic              rsp_fault;

    modport slave (
        input  req_valid, req_store, req_size, req_addr, req_wdata, req_tag,
        input  mem_dataout, rsp_ready,
        output req_ready, mem_raddress, mem_waddress, mem_datain, mem_wr,
        output rsp_valid, rsp_data, rsp_tag, rsp_fault
    );

    modport master (
        output req_valid, req_store, req_size, req_addr, req_wdata, req_tag,
        output mem_dataout, rsp_ready,
        input  req_ready, mem_raddress, mem_waddress, mem_datain, mem_wr,
        input  rsp_valid, rsp_data, rsp_tag, rsp_fault
    );

endinterface

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of raw memory read data according to the access size.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  lsu_size_e   size,
    input  logic [31:0] raw,
    output logic [31:0] data
);

    always_comb begin
        data = raw;
        case (size)
            SIZE_B:  data = {{24{raw[7]}}, raw[7:0]};
            SIZE_BU: data = {24'h000000, raw[7:0]};
            SIZE_H:  data = {{16{raw[15]}}, raw[15:0]};
            SIZE_HU: data = {16'h0000, raw[15:0]};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between the MEM stage and the byte-banked data memory.
// Optional misalignment trapping is enabled with `define LSU_MISALIGN_TRAP_EN.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int MEM_RD_LAT = 1,
    parameter int ADDR_W     = 32
) (
    input  logic           Clk,
    input  logic           Reset_n,
    lsu_mem_ctrl_if.slave  bus
);

    localparam logic [1:0] LAT_INIT = 2'(MEM_RD_LAT - 1);

    lsu_state_e        state, next_state;
    logic [ADDR_W-1:0] addr_q;
    lsu_size_e         size_q;
    logic [4:0]        tag_q;
    logic [1:0]        cnt_q;
    logic [31:0]       data_q;
    logic [31:0]       ext_data;
    lsu_size_e         req_size_dec;
    logic              accept;
    logic              misaligned;

    assign req_size_dec = decode_size(bus.req_size);
    assign accept       = bus.req_valid && bus.req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
    logic fault_q;

    assign misaligned = (((req_size_dec == SIZE_H) || (req_size_dec == SIZE_HU)) && bus.req_addr[0])
                     || ((req_size_dec == SIZE_W) && (bus.req_addr[1:0] != 2'b00));
    assign bus.rsp_fault = fault_q;
`else
    assign misaligned    = 1'b0;
    assign bus.rsp_fault = 1'b0;
`endif

    lsu_load_extend u_load_extend (
        .size (size_q),
        .raw  (bus.mem_dataout),
        .data (ext_data)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Stores and trapped accesses commit in the accept cycle and go straight
    // to RESP; the accept-cycle address is combinational so the write lands
    // on the same edge that the request is taken.
    always_comb begin
        next_state       = state;
        bus.req_ready    = 1'b0;
        bus.mem_wr       = 4'b0000;
        bus.mem_datain   = 32'h0000_0000;
        bus.mem_raddress = addr_q;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    bus.mem_raddress = bus.req_addr;
                    if (misaligned) begin
                        next_state = RESP;
                    end else if (bus.req_store) begin
                        bus.mem_wr     = byte_enables(req_size_dec);
                        bus.mem_datain = bus.req_wdata;
                        next_state     = RESP;
                    end else begin
                        next_state = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q == 2'd0) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign bus.mem_waddress = bus.mem_raddress;
    assign bus.rsp_valid    = (state == RESP);
    assign bus.rsp_data     = data_q;
    assign bus.rsp_tag      = tag_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            addr_q  <= '0;
            size_q  <= SIZE_W;
            tag_q   <= 5'd0;
            cnt_q   <= 2'd0;
            data_q  <= 32'h0000_0000;
`ifdef LSU_MISALIGN_TRAP_EN
            fault_q <= 1'b0;
`endif
        end else if (accept) begin
            addr_q  <= bus.req_addr;
            size_q  <= req_size_dec;
            tag_q   <= bus.req_tag;
            cnt_q   <= LAT_INIT;
            data_q  <= 32'h0000_0000;
`ifdef LSU_MISALIGN_TRAP_EN
            fault_q <= misaligned;
`endif
        end else if (state == RD_WAIT) begin
            if (cnt_q == 2'd0) begin
                data_q <= ext_data;
            end else begin
                cnt_q <= cnt_q - 2'd1;
            end
        end
    end

endmodule
